jtframe_lfbuf_linewr: RTL and testbench



---
 rtl/jtframe_lfbuf_pkg.sv | 19 +
 rtl/jtframe_lfbuf_linewr.sv | 143 ++++++++++++++
 tb/tb_jtframe_lfbuf_linewr.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/jtframe_lfbuf_pkg.sv
// Shared definitions for the line-frame buffer and its game-side line writer.
// Optional feature macro: JTFRAME_LINEWR_TIMEOUT_EN (adds the PAD state).
package jtframe_lfbuf_pkg;

  localparam int LFBUF_AW = 9;   // default line address width
  localparam int LFBUF_DW = 16;  // default pixel width
  localparam int LFBUF_VW = 8;   // line number width

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    FILL  = 3'd2,
    DONE  = 3'd3
`ifdef JTFRAME_LINEWR_TIMEOUT_EN
    , PAD = 3'd4
`endif
  } lw_state_t;

endpackage

// File: rtl/jtframe_lfbuf_linewr.sv
// Game-side line writer: on each ln_hs rising edge it latches the line number,
// starts the renderer, streams WIDTH pixels into consecutive line addresses and
// pulses ln_done. A new edge before completion abandons the line (overrun).
// Optional feature macro: JTFRAME_LINEWR_TIMEOUT_EN -- a stalled renderer is
// timed out after TOUT idle cycles and the rest of the line is padded with zeros.
module jtframe_lfbuf_linewr
  import jtframe_lfbuf_pkg::*;
#(
  parameter int AW    = LFBUF_AW,
  parameter int DW    = LFBUF_DW,
  parameter int WIDTH = 256,
  parameter int TOUT  = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ln_hs,
  input  logic [LFBUF_VW-1:0] ln_v,
  output logic [AW-1:0]       ln_addr,
  output logic [DW-1:0]       ln_data,
  output logic                ln_we,
  output logic                ln_done,
  output logic [LFBUF_VW-1:0] rd_v,
  output logic                rd_start,
  input  logic                px_valid,
  input  logic [DW-1:0]       px_data,
  output logic                px_ready,
  output logic                busy,
  output logic                overrun
);

  localparam logic [AW:0] CNT_LAST = (AW+1)'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > (1 << AW) || TOUT < 1) begin : g_bad_cfg
    $error("jtframe_lfbuf_linewr: WIDTH must be 2..2**AW and TOUT >= 1");
  end

  lw_state_t   state, nx_state;
  logic        hs_l;
  logic        hs_edge;
  logic [AW:0] cnt;
  logic        accept;
  logic        wr;
  logic        stall_hit;
  logic        pad_wr;

  assign hs_edge  = ln_hs & ~hs_l;
  assign px_ready = (state == FILL);
  assign accept   = px_valid & px_ready;
  assign wr       = accept | pad_wr;
  assign busy     = (state != IDLE);

`ifdef JTFRAME_LINEWR_TIMEOUT_EN
  localparam int SW = $clog2(TOUT + 1);
  logic [SW-1:0] stall;

  // Stall counter: idle FILL cycles since the last acceptance or FILL entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall <= '0;
    end else if (state != FILL || accept) begin
      stall <= '0;
    end else begin
      stall <= stall + SW'(1);
    end
  end

  assign stall_hit = (state == FILL) && !accept && (stall == SW'(TOUT - 1));
  assign pad_wr    = (state == PAD);
`else
  assign stall_hit = 1'b0;
  assign pad_wr    = 1'b0;
`endif

  // Next-state logic; any hs edge restarts the line from START.
  always_comb begin
    nx_state = state;
    case (state)
      IDLE:  nx_state = IDLE;
      START: nx_state = FILL;
      FILL: begin
        if (accept && cnt == CNT_LAST) begin
          nx_state = DONE;
`ifdef JTFRAME_LINEWR_TIMEOUT_EN
        end else if (stall_hit) begin
          nx_state = PAD;
`endif
        end else begin
          nx_state = FILL;
        end
      end
`ifdef JTFRAME_LINEWR_TIMEOUT_EN
      PAD: begin
        if (cnt == CNT_LAST) begin
          nx_state = DONE;
        end else begin
          nx_state = PAD;
        end
      end
`endif
      DONE:    nx_state = IDLE;
      default: nx_state = IDLE;
    endcase
    if (hs_edge) begin
      nx_state = START;
    end else begin
      nx_state = nx_state;
    end
  end

  // State, edge history, pixel counter and registered line/renderer outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hs_l     <= 1'b0;
      cnt      <= '0;
      ln_addr  <= '0;
      ln_data  <= '0;
      ln_we    <= 1'b0;
      ln_done  <= 1'b0;
      rd_v     <= '0;
      rd_start <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= nx_state;
      hs_l     <= ln_hs;
      ln_we    <= wr;
      rd_start <= (state == START) && !hs_edge;
      ln_done  <= (state == DONE) && !hs_edge;
      overrun  <= (hs_edge && state != IDLE) || stall_hit;
      if (wr) begin
        ln_addr <= cnt[AW-1:0];
        ln_data <= pad_wr ? DW'(0) : px_data;
      end
      if (hs_edge) begin
        rd_v <= ln_v;
        cnt  <= '0;
      end else if (wr) begin
        cnt  <= cnt + (AW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_jtframe_lfbuf_linewr.sv
// Self-checking bench for jtframe_lfbuf_linewr (WIDTH=8). The timeout case is
// compiled only with JTFRAME_LINEWR_TIMEOUT_EN defined.
module tb_jtframe_lfbuf_linewr;

  localparam int AW = 9, DW = 16, WIDTH = 8, TOUT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ln_hs;
  logic [7:0]    ln_v;
  logic [AW-1:0] ln_addr;
  logic [DW-1:0] ln_data;
  logic          ln_we, ln_done, rd_start, px_valid, px_ready, busy, overrun;
  logic [7:0]    rd_v;
  logic [DW-1:0] px_data;

  int n_cmp = 0;
  int n_err = 0;

  jtframe_lfbuf_linewr #(.AW(AW), .DW(DW), .WIDTH(WIDTH), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .ln_hs(ln_hs), .ln_v(ln_v),
    .ln_addr(ln_addr), .ln_data(ln_data), .ln_we(ln_we), .ln_done(ln_done),
    .rd_v(rd_v), .rd_start(rd_start), .px_valid(px_valid), .px_data(px_data),
    .px_ready(px_ready), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hs;
    logic [7:0]  v;
    logic        pv;
    logic [15:0] pd;
    logic        we;
    logic [8:0]  addr;
    logic [15:0] data;
    logic        done, start, bsy, rdy, ov;
    logic [7:0]  rdv;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [38:0] outs();
    return {ln_we, ln_addr, ln_data, ln_done, rd_start, busy, px_ready, overrun, rd_v};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Streams one line from FILL; gap=1 uses a valid pattern 1,0,0,1,0,0...
  task automatic collect_line(input logic [15:0] base, input bit gap, input string tag);
    int acc = 0, wrn = 0, dn = 0, ov = 0, ph = 0, last_we = -10, done_c = 0;
    bit fin = 1'b0;
    logic v;
    for (int c = 0; c < 100 && !fin; c++) begin
      v = gap ? ((ph % 3) == 0) : 1'b1;
      px_valid = v;
      px_data  = base + 16'(acc);
      if (v && px_ready) acc++;
      ph++;
      step();
      if (ln_we) begin
        check({tag, " addr"}, 64'(ln_addr), 64'(wrn));
        check({tag, " data"}, 64'(ln_data), 64'(base + 16'(wrn)));
        wrn++;
        last_we = c;
      end
      if (overrun) ov++;
      if (ln_done) begin
        dn++;
        done_c = c;
        fin = 1'b1;
      end
    end
    px_valid = 1'b0;
    check({tag, " write count"}, 64'(wrn), 64'(WIDTH));
    check({tag, " done count"}, 64'(dn), 64'd1);
    check({tag, " done delay"}, 64'(done_c - last_we), 64'd1);
    check({tag, " overruns"}, 64'(ov), 64'd0);
    step();
    check({tag, " idle after"}, {62'd0, ln_done, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ln_hs = 1'b0; ln_v = 8'h00; px_valid = 1'b0; px_data = 16'h0000;

    // basic line: edge with ln_v=5A, then ln_v changed, hs held high
    tbl[0]  = '{1'b1, 8'h5A, 1'b1, 16'h0100, 1'b0, 9'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A};
    tbl[1]  = '{1'b1, 8'h00, 1'b1, 16'h0100, 1'b0, 9'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h5A};
    for (int i = 0; i < 8; i++) begin
      tbl[2+i] = '{1'b1, 8'h00, 1'b1, 16'h0100 + 16'(i), 1'b1, 9'(i), 16'h0100 + 16'(i),
                   1'b0, 1'b0, 1'b1, (i < 7) ? 1'b1 : 1'b0, 1'b0, 8'h5A};
    end
    tbl[10] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 9'd7, 16'h0107, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 9'd7, 16'h0107, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A};

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 64'(outs()), 64'd0);
    rst = 1'b0;
    step();
    check("idle outputs", 64'(outs()), 64'd0);

    for (int i = 0; i < 12; i++) begin
      ln_hs = tbl[i].hs; ln_v = tbl[i].v; px_valid = tbl[i].pv; px_data = tbl[i].pd;
      step();
      check($sformatf("vec%0d", i), 64'(outs()),
            64'({tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].done, tbl[i].start,
                 tbl[i].bsy, tbl[i].rdy, tbl[i].ov, tbl[i].rdv}));
    end

    // valid gaps
    ln_hs = 1'b1; ln_v = 8'h33; step();
    ln_hs = 1'b0; ln_v = 8'h00; step();
    check("gap rd_start", {63'd0, rd_start}, 64'd1);
    check("gap rd_v", 64'(rd_v), 64'h33);
    collect_line(16'h0200, 1'b1, "gap");

    // overrun after 3 accepted pixels
    ln_hs = 1'b1; ln_v = 8'h11; step();
    ln_hs = 1'b0; step();
    for (int i = 0; i < 3; i++) begin
      px_valid = 1'b1; px_data = 16'h0300 + 16'(i); step();
      check("ovr pre addr", 64'({ln_we, ln_addr}), 64'({1'b1, 9'(i)}));
    end
    ln_hs = 1'b1; ln_v = 8'h22; px_valid = 1'b0; step();
    check("ovr pulse", {59'd0, overrun, ln_done, ln_we, busy, rd_start}, 64'b10010);
    check("ovr rd_v", 64'(rd_v), 64'h22);
    step();
    check("ovr single", {61'd0, overrun, rd_start, ln_done}, 64'b010);
    collect_line(16'h0400, 1'b0, "restart");

    // async reset mid-line
    ln_hs = 1'b0; step();
    ln_hs = 1'b1; ln_v = 8'h44; step();
    ln_hs = 1'b0; step();
    for (int i = 0; i < 4; i++) begin
      px_valid = 1'b1; px_data = 16'h0500 + 16'(i); step();
    end
    check("pre-reset write", 64'({ln_we, ln_addr, ln_data}), 64'({1'b1, 9'd3, 16'h0503}));
    #2 rst = 1'b1;
    #1 check("async reset", 64'(outs()), 64'd0);
    px_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    check("held reset", 64'(outs()), 64'd0);
    ln_hs = 1'b1; ln_v = 8'h55; step();
    ln_hs = 1'b0; step();
    check("post-reset start", 64'({rd_start, rd_v}), 64'({1'b1, 8'h55}));
    collect_line(16'h0600, 1'b0, "after_rst");

`ifdef JTFRAME_LINEWR_TIMEOUT_EN
    begin
      int idle = 0, ovc = 0, padw = 0, pada = 5, dn = 0, hit = -1;
      ln_hs = 1'b1; ln_v = 8'h66; step();
      ln_hs = 1'b0; step();
      for (int i = 0; i < 5; i++) begin
        px_valid = 1'b1; px_data = 16'h0700 + 16'(i); step();
      end
      px_valid = 1'b0;
      for (int c = 0; c < 80 && dn == 0; c++) begin
        step();
        idle++;
        if (overrun) begin ovc++; hit = idle; end
        if (ln_we) begin
          check("pad addr", 64'(ln_addr), 64'(pada));
          check("pad data", 64'(ln_data), 64'd0);
          pada++; padw++;
        end
        if (ln_done) dn++;
      end
      check("tout cycle", 64'(hit), 64'(TOUT));
      check("tout overruns", 64'(ovc), 64'd1);
      check("pad writes", 64'(padw), 64'd3);
      check("tout done", 64'(dn), 64'd1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
